// File: rtl/esfa_pkg.sv
// Purpose : shared opcodes, cell selector codes, FSM state type and helpers for the sequencer.
// Latency : n/a (types, constants and pure functions only).
// Backpr. : n/a.
package esfa_pkg;

   localparam int DEFAULT_NCELLS = 8;

   // Command opcodes; 3'd5 and 3'd7 are illegal.
   localparam logic [2:0] OP_NEW    = 3'd0;
   localparam logic [2:0] OP_LOOKUP = 3'd1;
   localparam logic [2:0] OP_ENCODE = 3'd2;
   localparam logic [2:0] OP_INSERT = 3'd3;
   localparam logic [2:0] OP_REMOVE = 3'd4;
   localparam logic [2:0] OP_ENRANK = 3'd6;

   // Cell selector codes broadcast to every cell.
   localparam logic [7:0] SEL_NEW_WRITE    = 8'd0;
   localparam logic [7:0] SEL_LOOKUP       = 8'd1;
   localparam logic [7:0] SEL_ENCODE       = 8'd2;
   localparam logic [7:0] SEL_INSERT_WRITE = 8'd3;
   localparam logic [7:0] SEL_REMOVE       = 8'd4;
   localparam logic [7:0] SEL_FREE_QUERY   = 8'd5;
   localparam logic [7:0] SEL_ENRANK       = 8'd6;
   localparam logic [7:0] SEL_RSVD7        = 8'd7;
   localparam logic [7:0] SEL_RSVD8        = 8'd8;
   localparam logic [7:0] SEL_IDLE         = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_PICK,
      ST_WRITE,
      ST_WWAIT,
      ST_RESP
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return !(op == 3'd5 || op == 3'd7);
   endfunction

   // NEW and INSERT need a free-cell search followed by a write phase.
   function automatic logic op_two_phase(input logic [2:0] op);
      return (op == OP_NEW) || (op == OP_INSERT);
   endfunction

   function automatic logic [7:0] issue_sel(input logic [2:0] op);
      logic [7:0] sel;
      sel = SEL_IDLE;
      case (op)
         OP_NEW, OP_INSERT: sel = SEL_FREE_QUERY;
         OP_LOOKUP:         sel = SEL_LOOKUP;
         OP_ENCODE:         sel = SEL_ENCODE;
         OP_REMOVE:         sel = SEL_REMOVE;
         OP_ENRANK:         sel = SEL_ENRANK;
         default:           sel = SEL_IDLE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/esfa_if.sv
// Purpose : command/response handshake bundle between a host and the sequencer.
// Latency : n/a (wires only).
// Backpr. : cmd_ready throttles the host; rsp_ready holds the sequencer's response.
// Ports   : cmd_valid/cmd_ready + cmd_op/handle/index/value/code/rank,
//           rsp_valid/rsp_ready + rsp_ok/value/context.
interface esfa_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_handle;
   logic [7:0] cmd_index;
   logic [7:0] cmd_value;
   logic [7:0] cmd_code;
   logic [7:0] cmd_rank;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_ok;
   logic [7:0] rsp_value;
   logic [7:0] rsp_context;

   modport master (
      output cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, cmd_code, cmd_rank, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_ok, rsp_value, rsp_context
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, cmd_code, cmd_rank, rsp_ready,
      output cmd_ready, rsp_valid, rsp_ok, rsp_value, rsp_context
   );
endinterface

// File: rtl/esfa_prio_enc.sv
// Purpose : lowest-set-bit priority encoder over an N-bit vector.
// Latency : combinational.
// Backpr. : none.
// Ports   : vec (N bits) in; found flag and idx (lowest set position) out; idx=0 when none set.
module esfa_prio_enc #(
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  vec,
   output logic          found,
   output logic [IW-1:0] idx
);

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            found = 1'b1;
            idx   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/esfa_sequencer.sv
// Purpose : sequences commands onto a broadcast bus of NCELLS memory cells and gathers their replies.
// Latency : response 2 edges after accept (single-phase), 5 (NEW/INSERT), 3 (no free cell), 1 (illegal).
// Backpr. : cmd_ready only in IDLE; response held stable in RESP until rsp_ready.
// Ports   : clk, reset (sync, active-low), bus (esfa_if.slave), cell broadcast outputs
//           (selector, operands, qualifiers), cell_bool/result/context gathered inputs.
module esfa_sequencer
   import esfa_pkg::*;
#(
   parameter int NCELLS = DEFAULT_NCELLS
) (
   input  logic                clk,
   input  logic                reset,
   esfa_if.slave               bus,
   output logic [7:0]          selector,
   output logic [7:0]          queried_handle,
   output logic [7:0]          available_handle,
   output logic [7:0]          inserted_index,
   output logic [7:0]          inserted_value,
   output logic [7:0]          given_code,
   output logic [7:0]          given_rank,
   output logic                is_available_handle,
   output logic                is_given_code,
   output logic                is_given_rank,
   input  logic [NCELLS-1:0]   cell_bool,
   input  logic [8*NCELLS-1:0] cell_result,
   input  logic [8*NCELLS-1:0] cell_context
);

   localparam int IW = (NCELLS > 1) ? $clog2(NCELLS) : 1;

   state_t          state;
   logic [2:0]      op_q;
   logic            illegal_pend;
   logic            free_found;
   logic [IW-1:0]   free_idx;
   logic            enc_found;
   logic [IW-1:0]   enc_idx;
   logic [7:0]      res_arr [NCELLS];
   logic [7:0]      ctx_arr [NCELLS];

   esfa_prio_enc #(.N(NCELLS), .IW(IW)) u_enc (
      .vec   (cell_bool),
      .found (enc_found),
      .idx   (enc_idx)
   );

   always_comb begin
      for (int i = 0; i < NCELLS; i++) begin
         res_arr[i] = cell_result[8*i +: 8];
         ctx_arr[i] = cell_context[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state               <= ST_IDLE;
         op_q                <= 3'd0;
         illegal_pend        <= 1'b0;
         free_found          <= 1'b0;
         free_idx            <= '0;
         selector            <= SEL_IDLE;
         queried_handle      <= 8'd0;
         available_handle    <= 8'd0;
         inserted_index      <= 8'd0;
         inserted_value      <= 8'd0;
         given_code          <= 8'd0;
         given_rank          <= 8'd0;
         is_available_handle <= 1'b0;
         is_given_code       <= 1'b0;
         is_given_rank       <= 1'b0;
         bus.cmd_ready       <= 1'b0;
         bus.rsp_valid       <= 1'b0;
         bus.rsp_ok          <= 1'b0;
         bus.rsp_value       <= 8'd0;
         bus.rsp_context     <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (illegal_pend) begin
                  // Illegal ops spend one edge here so the response lands one edge after accept.
                  illegal_pend    <= 1'b0;
                  bus.rsp_valid   <= 1'b1;
                  bus.rsp_ok      <= 1'b0;
                  bus.rsp_value   <= 8'd0;
                  bus.rsp_context <= 8'd0;
                  state           <= ST_RESP;
               end else begin
                  bus.cmd_ready <= 1'b1;
                  if (bus.cmd_valid && bus.cmd_ready) begin
                     bus.cmd_ready  <= 1'b0;
                     op_q           <= bus.cmd_op;
                     queried_handle <= bus.cmd_handle;
                     inserted_index <= bus.cmd_index;
                     inserted_value <= bus.cmd_value;
                     given_code     <= bus.cmd_code;
                     given_rank     <= bus.cmd_rank;
                     is_given_code  <= bus.cmd_op inside {OP_LOOKUP, OP_INSERT, OP_REMOVE};
                     is_given_rank  <= (bus.cmd_op == OP_INSERT);
                     if (op_legal(bus.cmd_op)) begin
                        selector <= issue_sel(bus.cmd_op);
                        state    <= ST_ISSUE;
                     end else begin
                        illegal_pend <= 1'b1;
                     end
                  end
               end
            end

            ST_ISSUE: begin
               selector <= SEL_IDLE;
               state    <= ST_WAIT;
            end

            ST_WAIT: begin
               if (op_two_phase(op_q)) begin
                  // Cells answered the free query; remember the lowest free one.
                  free_found <= enc_found;
                  free_idx   <= enc_idx;
                  state      <= ST_PICK;
               end else begin
                  bus.rsp_valid   <= 1'b1;
                  bus.rsp_ok      <= |cell_bool;
                  bus.rsp_value   <= enc_found ? res_arr[enc_idx] : 8'd0;
                  bus.rsp_context <= enc_found ? ctx_arr[enc_idx] : 8'd0;
                  state           <= ST_RESP;
               end
            end

            ST_PICK: begin
               if (!free_found) begin
                  bus.rsp_valid   <= 1'b1;
                  bus.rsp_ok      <= 1'b0;
                  bus.rsp_value   <= 8'hFF;
                  bus.rsp_context <= 8'd0;
                  state           <= ST_RESP;
               end else begin
                  selector            <= (op_q == OP_NEW) ? SEL_NEW_WRITE : SEL_INSERT_WRITE;
                  available_handle    <= 8'(free_idx);
                  is_available_handle <= 1'b1;
                  state               <= ST_WRITE;
               end
            end

            ST_WRITE: begin
               selector            <= SEL_IDLE;
               is_available_handle <= 1'b0;
               state               <= ST_WWAIT;
            end

            ST_WWAIT: begin
               bus.rsp_valid   <= 1'b1;
               bus.rsp_ok      <= cell_bool[free_idx];
               bus.rsp_value   <= 8'(free_idx);
               bus.rsp_context <= (op_q == OP_NEW) ? ctx_arr[free_idx] : 8'd0;
               state           <= ST_RESP;
            end

            ST_RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  state         <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_esfa_sequencer.sv
// Purpose : directed self-checking bench for esfa_sequencer with a behavioural model of 8 cells.
// Latency : checks response latency per command class against hand-computed edge counts.
// Backpr. : exercises held rsp_ready and cmd_ready gating.
module tb_esfa_sequencer;
   import esfa_pkg::*;

   localparam int N = 8;

   logic clk;
   logic reset;
   esfa_if bus ();

   logic [7:0]     selector, queried_handle, available_handle, inserted_index, inserted_value;
   logic [7:0]     given_code, given_rank;
   logic           is_available_handle, is_given_code, is_given_rank;
   logic [N-1:0]   cell_bool;
   logic [8*N-1:0] cell_result, cell_context;

   int tests_run;
   int tests_failed;

   esfa_sequencer #(.NCELLS(N)) dut (
      .clk                 (clk),
      .reset               (reset),
      .bus                 (bus.slave),
      .selector            (selector),
      .queried_handle      (queried_handle),
      .available_handle    (available_handle),
      .inserted_index      (inserted_index),
      .inserted_value      (inserted_value),
      .given_code          (given_code),
      .given_rank          (given_rank),
      .is_available_handle (is_available_handle),
      .is_given_code       (is_given_code),
      .is_given_rank       (is_given_rank),
      .cell_bool           (cell_bool),
      .cell_result         (cell_result),
      .cell_context        (cell_context)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   // Cell model: cell i has handle i; replies are registered when a non-idle selector is seen,
   // and only on the first such edge after an idle-selector edge (write-once guard).
   logic       c_used [N];
   logic [7:0] c_idx  [N];
   logic [7:0] c_val  [N];
   logic [7:0] c_code [N];
   logic [7:0] c_rank [N];
   logic       armed;

   always @(posedge clk) begin
      if (!reset) begin
         armed        <= 1'b1;
         cell_bool    <= '0;
         cell_result  <= '0;
         cell_context <= '0;
         for (int i = 0; i < N; i++) begin
            c_used[i] <= 1'b0;
            c_idx[i]  <= 8'd0;
            c_val[i]  <= 8'd0;
            c_code[i] <= 8'd0;
            c_rank[i] <= 8'd0;
         end
      end else begin
         armed <= (selector == 8'hFF);
         if (selector != 8'hFF && armed) begin
            for (int i = 0; i < N; i++) begin
               cell_bool[i]          <= 1'b0;
               cell_result[8*i +: 8]  <= 8'd0;
               cell_context[8*i +: 8] <= 8'd0;
               case (selector)
                  8'd5: cell_bool[i] <= !c_used[i];
                  8'd0, 8'd3: if (is_available_handle && available_handle == 8'(i)) begin
                     c_used[i] <= 1'b1;
                     c_idx[i]  <= inserted_index;
                     c_val[i]  <= inserted_value;
                     c_code[i] <= (selector == 8'd3) ? given_code : 8'd0;
                     c_rank[i] <= (selector == 8'd3) ? given_rank : 8'd1;
                     cell_bool[i] <= 1'b1;
                     cell_context[8*i +: 8] <= (selector == 8'd3) ? given_rank : 8'd1;
                  end
                  8'd1: if (c_used[i] && c_idx[i] == inserted_index &&
                            (!is_given_code || c_code[i] == given_code)) begin
                     cell_bool[i] <= 1'b1;
                     cell_result[8*i +: 8]  <= c_val[i];
                     cell_context[8*i +: 8] <= c_rank[i];
                  end
                  8'd2: if (c_used[i] && queried_handle == 8'(i)) begin
                     cell_bool[i] <= 1'b1;
                     cell_result[8*i +: 8]  <= c_code[i];
                     cell_context[8*i +: 8] <= c_idx[i];
                  end
                  8'd4: if (c_used[i] && queried_handle == 8'(i) && c_code[i] == given_code) begin
                     c_used[i] <= 1'b0;
                     cell_bool[i] <= 1'b1;
                     cell_result[8*i +: 8]  <= c_val[i];
                     cell_context[8*i +: 8] <= c_idx[i];
                  end
                  8'd6: if (c_used[i] && queried_handle == 8'(i)) begin
                     cell_bool[i] <= 1'b1;
                     cell_result[8*i +: 8] <= c_rank[i];
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Selector history: every non-idle selector value shifts in; avail_n counts write cycles.
   logic [23:0] sel_w;
   int          sel_n;
   int          avail_n;
   logic [7:0]  avail_last;

   initial begin
      sel_w      = 24'd0;
      sel_n      = 0;
      avail_n    = 0;
      avail_last = 8'd0;
      forever begin
         @(negedge clk);
         if (selector != 8'hFF) begin
            sel_w = {sel_w[15:0], selector};
            sel_n = sel_n + 1;
         end
         if (is_available_handle) begin
            avail_last = available_handle;
            avail_n    = avail_n + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one command, scramble operands after accept, then check latency, payload,
   // selector signature {count, last selectors}, hold stability and the handshake.
   task automatic do_cmd(input string tag, input logic [2:0] op, input logic [7:0] h, input logic [7:0] ix,
                         input logic [7:0] v, input logic [7:0] c, input logic [7:0] r, input int hold,
                         input int e_lat, input logic e_ok, input logic [7:0] e_val,
                         input logic [7:0] e_ctx, input logic [31:0] e_sig);
      int n;
      int n0;
      int cnt;
      int lat;
      logic [23:0] mask;
      logic [31:0] sig;
      @(negedge clk);
      n0             = sel_n;
      bus.cmd_op     = op;
      bus.cmd_handle = h;
      bus.cmd_index  = ix;
      bus.cmd_value  = v;
      bus.cmd_code   = c;
      bus.cmd_rank   = r;
      bus.cmd_valid  = 1'b1;
      n = 0;
      while (!bus.cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_accept"}, 32'(bus.cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 3'd2;
      bus.cmd_handle = 8'hA5;
      bus.cmd_index  = 8'h5A;
      bus.cmd_value  = 8'hC3;
      bus.cmd_code   = 8'h3C;
      bus.cmd_rank   = 8'h99;
      lat = 0;
      while (!bus.rsp_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
      chk({tag, "_ok"}, 32'(bus.rsp_ok), 32'(e_ok));
      chk({tag, "_val"}, 32'(bus.rsp_value), 32'(e_val));
      chk({tag, "_ctx"}, 32'(bus.rsp_context), 32'(e_ctx));
      cnt  = sel_n - n0;
      mask = (cnt >= 3) ? 24'hFFFFFF : (cnt == 2) ? 24'h00FFFF : (cnt == 1) ? 24'h0000FF : 24'h0;
      sig  = {8'(cnt), sel_w & mask};
      chk({tag, "_sel"}, sig, e_sig);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1;
         chk({tag, "_hold_vld"}, 32'(bus.rsp_valid), 32'd1);
         chk({tag, "_hold_rdy"}, 32'(bus.cmd_ready), 32'd0);
         chk({tag, "_hold_payload"}, {15'd0, bus.rsp_ok, bus.rsp_value, bus.rsp_context},
             {15'd0, e_ok, e_val, e_ctx});
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      chk({tag, "_done_vld"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_done_rdy"}, 32'(bus.cmd_ready), 32'd1);
   endtask

   int a0;
   int n;

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      reset          = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 3'd0;
      bus.cmd_handle = 8'd0;
      bus.cmd_index  = 8'd0;
      bus.cmd_value  = 8'd0;
      bus.cmd_code   = 8'd0;
      bus.cmd_rank   = 8'd0;
      bus.rsp_ready  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_selector", 32'(selector), 32'hFF);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rst_payload", {15'd0, bus.rsp_ok, bus.rsp_value, bus.rsp_context}, 32'd0);
      chk("rst_bus_ops", {queried_handle, available_handle, inserted_index, inserted_value}, 32'd0);
      chk("rst_bus_misc", {given_code, given_rank, 5'd0, is_available_handle, is_given_code, is_given_rank},
          32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      a0 = avail_n;
      do_cmd("new0", OP_NEW, 8'h00, 8'h03, 8'h5A, 8'h00, 8'h00, 0, 5, 1'b1, 8'h00, 8'h01, 32'h02000500);
      chk("new0_avail_cnt", 32'(avail_n - a0), 32'd1);
      chk("new0_avail_handle", 32'(avail_last), 32'd0);
      do_cmd("lookup0", OP_LOOKUP, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 0, 2, 1'b1, 8'h5A, 8'h01, 32'h01000001);
      do_cmd("illegal7", 3'd7, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 0, 1, 1'b0, 8'h00, 8'h00, 32'h0);
      do_cmd("illegal5", 3'd5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 0, 1, 1'b0, 8'h00, 8'h00, 32'h0);
      do_cmd("remove0", OP_REMOVE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4, 2, 1'b1, 8'h5A, 8'h03, 32'h01000004);
      do_cmd("encode_gone", OP_ENCODE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2, 1'b0, 8'h00, 8'h00, 32'h01000002);

      for (int k = 0; k < 8; k++) begin
         do_cmd("fill", OP_NEW, 8'h00, 8'(16 + k), 8'(k), 8'h00, 8'h00, 0, 5, 1'b1, 8'(k), 8'h01, 32'h02000500);
      end
      a0 = avail_n;
      do_cmd("new_full", OP_NEW, 8'h00, 8'h40, 8'h41, 8'h00, 8'h00, 0, 3, 1'b0, 8'hFF, 8'h00, 32'h01000005);
      chk("new_full_no_write", 32'(avail_n - a0), 32'd0);
      do_cmd("lookup4", OP_LOOKUP, 8'h00, 8'd20, 8'h00, 8'h00, 8'h00, 0, 2, 1'b1, 8'h04, 8'h01, 32'h01000001);
      do_cmd("enrank5", OP_ENRANK, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2, 1'b1, 8'h01, 8'h00, 32'h01000006);
      do_cmd("remove2", OP_REMOVE, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2, 1'b1, 8'h02, 8'h12, 32'h01000004);

      // NEW into freed cell 2, abandoned by reset while the write selector is on the bus.
      @(negedge clk);
      bus.cmd_op    = OP_NEW;
      bus.cmd_index = 8'h09;
      bus.cmd_value = 8'h77;
      bus.cmd_valid = 1'b1;
      n = 0;
      while (!bus.cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rw_accept", 32'(bus.cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rw_in_write_sel", 32'(selector), 32'h00);
      chk("rw_in_write_avail", {24'd0, available_handle}, 32'd2);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rw_sel_idle", 32'(selector), 32'hFF);
      chk("rw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rw_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rw_avail_flag", 32'(is_available_handle), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rw_release_rdy", 32'(bus.cmd_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("rw_no_response", 32'(bus.rsp_valid), 32'd0);

      do_cmd("encode_after_rst", OP_ENCODE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2, 1'b0, 8'h00, 8'h00,
             32'h01000002);
      do_cmd("insert0", OP_INSERT, 8'h00, 8'h07, 8'h33, 8'h09, 8'h04, 0, 5, 1'b1, 8'h00, 8'h00, 32'h02000503);
      do_cmd("lookup_ins", OP_LOOKUP, 8'h00, 8'h07, 8'h00, 8'h09, 8'h00, 0, 2, 1'b1, 8'h33, 8'h04, 32'h01000001);
      do_cmd("lookup_badcode", OP_LOOKUP, 8'h00, 8'h07, 8'h00, 8'h08, 8'h00, 0, 2, 1'b0, 8'h00, 8'h00,
             32'h01000001);
      do_cmd("encode_ins", OP_ENCODE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2, 1'b1, 8'h09, 8'h07, 32'h01000002);
      do_cmd("enrank_ins", OP_ENRANK, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2, 1'b1, 8'h04, 8'h00, 32'h01000006);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
